// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multi-cycle controller
//
// Purpose: opcode and funct constants, state encodings, mux-select codes and
// small decode helpers shared by multicycle_ctrl and ctrl_wait_timer.
// Ports: none (package).

package multicycle_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  // Legal R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Sequencer states; codes 12-15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // ALUSrcB codes
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_legal_funct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  function automatic logic is_legal_opcode(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// rtl/multicycle_ctrl_wait_timer.sv - memory wait-state counter with timeout compare
//
// Purpose: counts consecutive cycles a memory state waits on ready and flags
// the cycle in which the wait reaches MEM_WAIT_MAX.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   active    - sequencer is in a memory-access state
//   ready     - memory completes the access this cycle
//   clear     - sequencer is changing state at the next edge
//   timeout   - combinational: this wait cycle is the MEM_WAIT_MAX-th one

module ctrl_wait_timer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  input  logic clear,
  output logic timeout
);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of waits already spent, so the current wait cycle is
  // number cnt+1; the timeout fires when that reaches MEM_WAIT_MAX.
  assign timeout = active && !ready && (cnt == CNT_W'(MEM_WAIT_MAX - 1));

  // A timeout returns FETCH to FETCH, which is not a state change, so it
  // clears the counter explicitly.
  always_ff @(posedge clk) begin
    if (rst || clear || timeout) begin
      cnt <= '0;
    end else if (active && !ready) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle instruction sequencer for the shared datapath
//
// Purpose: steps each instruction through FETCH/DECODE/EXEC/MEM/WB states and
// decodes datapath selects and enables from the current state, with a memory
// ready handshake and wait-state timeout.
// Optional feature macro: MULTICYCLE_PERF_EN builds the CycleCount and
// InstrCount performance counters; otherwise both ports are tied to 0.
// Ports:
//   CLK, RST                 - clock, synchronous active-high reset
//   OpCode, Funct            - instruction fields from the IR
//   Zero, MemReady           - ALU zero flag, memory access complete
//   PCWrite..PCSource        - datapath enables and mux selects
//   State                    - current state (debug)
//   IllegalOp, MemTimeout    - single-cycle event pulses
//   CycleCount, InstrCount   - performance counters

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        Mem2Reg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        ExtOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  State,
  output logic        IllegalOp,
  output logic        MemTimeout,
  output logic [31:0] CycleCount,
  output logic [31:0] InstrCount
);

  state_t state;
  state_t next_state;
  logic   mem_state;
  logic   timeout;
  logic   illegal_dec;

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  assign illegal_dec = (state == S_DECODE) &&
                       (!is_legal_opcode(OpCode) ||
                        ((OpCode == OP_RTYPE) && !is_legal_funct(Funct)));

  ctrl_wait_timer #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX),
    .CNT_W        (CNT_W)
  ) u_wait_timer (
    .clk     (CLK),
    .rst     (RST),
    .active  (mem_state),
    .ready   (MemReady),
    .clear   (next_state != state),
    .timeout (timeout)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (MemReady)     next_state = S_DECODE;
        else if (timeout) next_state = S_FETCH;
      end
      S_DECODE: begin
        if (illegal_dec) begin
          next_state = S_FETCH;
        end else begin
          case (OpCode)
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_RTYPE:     next_state = S_EXEC;
            OP_BEQ:       next_state = S_BRANCH;
            OP_J:         next_state = S_JUMP;
            OP_ORI:       next_state = S_IEXEC;
            default:      next_state = S_FETCH;
          endcase
        end
      end
      S_MEMADR: next_state = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (MemReady)     next_state = S_MEMWB;
        else if (timeout) next_state = S_FETCH;
      end
      S_MEMWR: begin
        if (MemReady || timeout) next_state = S_FETCH;
      end
      S_EXEC:   next_state = S_RWB;
      S_IEXEC:  next_state = S_IWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_FETCH;
    else     state <= next_state;
  end

  assign State = state;

  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    Mem2Reg  = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_RT;
    ALUOp    = ALUOP_ADD;
    ExtOp    = 1'b0;
    PCSource = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        PCSource = PCSRC_ALU;
        IRWrite  = MemReady;
        PCWrite  = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        ExtOp   = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ExtOp   = 1'b1;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        Mem2Reg  = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_RT;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_RT;
        ALUOp    = ALUOP_SUB;
        PCSource = PCSRC_ALUOUT;
        PCWrite  = Zero;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_OR;
      end
      S_IWB: begin
        RegWrite = 1'b1;
      end
      default: ;
    endcase

    // A timed-out access withdraws its request in the timeout cycle.
    if (timeout) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end

    if (RST) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign IllegalOp  = !RST && illegal_dec;
  assign MemTimeout = !RST && timeout;

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
  logic        instr_done;

  // Only states that finish an instruction count; illegal and timeout
  // returns to FETCH do not.
  assign instr_done = (state == S_MEMWB) || (state == S_RWB) ||
                      (state == S_BRANCH) || (state == S_JUMP) ||
                      (state == S_IWB) || ((state == S_MEMWR) && MemReady);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done) instr_cnt <= instr_cnt + 32'd1;
    end
  end

  assign CycleCount = cycle_cnt;
  assign InstrCount = instr_cnt;
`else
  assign CycleCount = 32'd0;
  assign InstrCount = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
//
// Purpose: directed and randomized instructions checked cycle by cycle
// against an instruction-level reference model.
// Ports: none (top-level bench).

module tb_multicycle_ctrl;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MRD = 4'd3, MWB = 4'd4,
                         MWR = 4'd5, EX = 4'd6, RWB_S = 4'd7, BR = 4'd8, JP = 4'd9,
                         IEX = 4'd10, IWB_S = 4'd11;

  // enable vector: {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IllegalOp, MemTimeout}
  localparam logic [6:0] PCW = 7'b1000000, IRW = 7'b0100000, RW = 7'b0010000,
                         MR = 7'b0001000, MW = 7'b0000100, ILL = 7'b0000010,
                         TO = 7'b0000001;

  logic        CLK, RST, Zero, MemReady;
  logic [5:0]  OpCode, Funct;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, Mem2Reg, RegWrite;
  logic        ALUSrcA, ExtOp, IllegalOp, MemTimeout;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  State;
  logic [31:0] CycleCount, InstrCount;

  multicycle_ctrl #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .Mem2Reg(Mem2Reg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ExtOp(ExtOp), .PCSource(PCSource), .State(State), .IllegalOp(IllegalOp),
    .MemTimeout(MemTimeout), .CycleCount(CycleCount), .InstrCount(InstrCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic [6:0] en;
    logic       done;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cycles = 0;
  int   exp_instr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {IorD, ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSource, RegDst, Mem2Reg}
  function automatic logic [11:0] sel_of(input logic [3:0] st);
    case (st)
      F:       return 12'b0_0_01_00_0_00_0_0;
      D:       return 12'b0_0_11_00_1_00_0_0;
      MA:      return 12'b0_1_10_00_1_00_0_0;
      MRD:     return 12'b1_0_00_00_0_00_0_0;
      MWB:     return 12'b0_0_00_00_0_00_0_1;
      MWR:     return 12'b1_0_00_00_0_00_0_0;
      EX:      return 12'b0_1_00_10_0_00_0_0;
      RWB_S:   return 12'b0_0_00_00_0_00_1_0;
      BR:      return 12'b0_1_00_01_0_01_0_0;
      JP:      return 12'b0_0_00_00_0_10_0_0;
      IEX:     return 12'b0_1_10_11_0_00_0_0;
      default: return 12'b0;
    endcase
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 || op == 6'h0D;
  endfunction

  function automatic logic legal_fn(input logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
  endfunction

  // Non-memory states ignore MemReady, so drive it randomly there.
  task automatic push(input logic [3:0] st, input logic [6:0] en, input logic done);
    cyc_t c;
    c.st = st; c.rdy = 1'($urandom_range(0, 1)); c.en = en; c.done = done;
    q.push_back(c);
  endtask

  // One memory access: w wait cycles then completion, or a timeout at wait 15.
  task automatic mem_phase(input logic [3:0] st, input int w, input logic fin, output bit to);
    cyc_t c;
    logic [6:0] req;
    req = (st == MWR) ? MW : MR;
    to = (w >= 15);
    c.st = st; c.done = 1'b0; c.rdy = 1'b0; c.en = req;
    for (int i = 0; i < (to ? 14 : w); i++) q.push_back(c);
    if (to) begin
      c.en = TO;
    end else begin
      c.rdy = 1'b1;
      c.en = req | ((st == F) ? (PCW | IRW) : 7'b0);
      c.done = fin;
    end
    q.push_back(c);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wf, input int wm);
    bit to;
    OpCode = op; Funct = fn; Zero = z;
    mem_phase(F, wf, 1'b0, to);
    if (to) return;
    if (!legal_op(op) || (op == 6'h00 && !legal_fn(fn))) begin
      push(D, ILL, 1'b0);
      return;
    end
    push(D, 7'b0, 1'b0);
    case (op)
      6'h23: begin
        push(MA, 7'b0, 1'b0);
        mem_phase(MRD, wm, 1'b0, to);
        if (!to) push(MWB, RW, 1'b1);
      end
      6'h2B: begin
        push(MA, 7'b0, 1'b0);
        mem_phase(MWR, wm, 1'b1, to);
      end
      6'h00: begin push(EX, 7'b0, 1'b0); push(RWB_S, RW, 1'b1); end
      6'h04: push(BR, z ? PCW : 7'b0, 1'b1);
      6'h02: push(JP, PCW, 1'b1);
      default: begin push(IEX, 7'b0, 1'b0); push(IWB_S, RW, 1'b1); end
    endcase
  endtask

  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      MemReady = c.rdy;
      @(negedge CLK);
      chk($sformatf("state(exp st %0d)", c.st), {28'b0, State}, {28'b0, c.st});
      chk($sformatf("enables(st %0d)", c.st),
          {25'b0, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IllegalOp, MemTimeout},
          {25'b0, c.en});
      chk($sformatf("selects(st %0d)", c.st),
          {20'b0, IorD, ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSource, RegDst, Mem2Reg},
          {20'b0, sel_of(c.st)});
`ifdef MULTICYCLE_PERF_EN
      chk("cycle_count", CycleCount, exp_cycles);
      chk("instr_count", InstrCount, exp_instr);
`else
      chk("cycle_count_tied", CycleCount, 32'd0);
      chk("instr_count_tied", InstrCount, 32'd0);
`endif
      @(posedge CLK);
      #1;
      exp_cycles++;
      if (c.done) exp_instr++;
    end
  endtask

  initial begin
    logic [5:0] fl [5];
    logic [5:0] op, fn;
    int         sel;
    fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25; fl[4] = 6'h2A;

    // Reset hold: enables stay low even with MemReady high.
    RST = 1'b1; OpCode = 6'h00; Funct = 6'h20; Zero = 1'b0; MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("reset_state", {28'b0, State}, 32'd0);
      chk("reset_enables", {27'b0, PCWrite, IRWrite, RegWrite, MemRead, MemWrite}, 32'd0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;

    // Directed: fetch with waits, lw, beq taken/not, sw waits, timeout, illegal.
    build(6'h23, 6'h00, 1'b0, 2, 0);  run_q();
    build(6'h23, 6'h00, 1'b0, 0, 0);  run_q();
    build(6'h04, 6'h00, 1'b1, 0, 0);  run_q();
    build(6'h04, 6'h00, 1'b0, 0, 0);  run_q();
    build(6'h2B, 6'h00, 1'b0, 0, 3);  run_q();
    build(6'h00, 6'h2A, 1'b0, 15, 0); run_q();
    build(6'h3F, 6'h00, 1'b0, 0, 0);  run_q();
    build(6'h00, 6'h3F, 1'b0, 0, 0);  run_q();
    build(6'h00, 6'h25, 1'b0, 0, 0);  run_q();
    build(6'h0D, 6'h00, 1'b0, 0, 0);  run_q();
    build(6'h02, 6'h00, 1'b0, 0, 0);  run_q();
    build(6'h23, 6'h00, 1'b0, 0, 15); run_q();
    build(6'h2B, 6'h00, 1'b0, 1, 15); run_q();

    // Randomized instruction mix.
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: op = 6'h23;
        1: op = 6'h2B;
        2: op = 6'h00;
        3: op = 6'h04;
        4: op = 6'h02;
        5: op = 6'h0D;
        6: op = 6'h00;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (legal_op(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      if ($urandom_range(0, 3) != 0) fn = fl[$urandom_range(0, 4)];
      else fn = 6'($urandom_range(0, 63));
      build(op, fn, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0) ? 15 : $urandom_range(0, 3),
            ($urandom_range(0, 11) == 0) ? 15 : $urandom_range(0, 3));
      run_q();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer that replaces the single-cycle Control decoder.
- Drives the shared ALU, register file and a single unified memory over several cycles per instruction: FETCH, DECODE, EXEC, MEM, WB.
- Adds a memory ready handshake with a wait-state timeout.
- Sits beside the datapath top level and feeds its mux selects and write enables.

Parameters:
- MEM_WAIT_MAX, 15, maximum consecutive wait cycles on MemReady before timeout.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MEM_WAIT_MAX.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- OpCode  in  6  instr[31:26] from the instruction register.
- Funct  in  6  instr[5:0]; used only to flag an illegal R-type.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write register select: 0 = rt, 1 = rd.
- Mem2Reg  out  1  write data select: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct, 11 = or.
- ExtOp  out  1  1 = sign extend, 0 = zero extend.
- PCSource  out  2  next PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- State  out  4  current state, for debug.
- IllegalOp  out  1  one-cycle pulse on an unsupported opcode.
- MemTimeout  out  1  one-cycle pulse on a wait timeout.
- CycleCount  out  32  performance counter; see Optional Feature.
- InstrCount  out  32  performance counter; see Optional Feature.

Behaviour:
- Clock and reset: single clock CLK. Reset RST is synchronous and active-high.
- Reset: RST=1 at an edge sets State=FETCH (0) and clears the wait counter and the perf counters.
- While RST=1, all write and request enables are forced to 0: PCWrite, IRWrite, RegWrite, MemRead, MemWrite.
- Output decode: outputs are decoded combinationally from State. The only Mealy terms are MemReady and Zero, as listed per state.
- States and transitions:
  - FETCH 0: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=MemReady. Go to DECODE on MemReady, else stay.
  - DECODE 1: ALUSrcA=0, ALUSrcB=11, ALUOp=00, ExtOp=1 (branch target into ALUOut). Next state by OpCode:
    - 0x23 or 0x2B -> MEMADR.
    - 0x00 -> EXEC.
    - 0x04 -> BRANCH.
    - 0x02 -> JUMP.
    - 0x0D -> IEXEC.
    - Any other opcode -> FETCH with an IllegalOp pulse.
  - MEMADR 2: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtOp=1. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD 3: IorD=1, MemRead=1. Go to MEMWB on MemReady.
  - MEMWB 4: RegDst=0, Mem2Reg=1, RegWrite=1. Go to FETCH.
  - MEMWR 5: IorD=1, MemWrite=1. Go to FETCH on MemReady.
  - EXEC 6: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RWB.
  - RWB 7: RegDst=1, Mem2Reg=0, RegWrite=1. Go to FETCH.
  - BRANCH 8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWrite=Zero. Go to FETCH.
  - JUMP 9: PCSource=10, PCWrite=1. Go to FETCH.
  - IEXEC 10: ALUSrcA=1, ALUSrcB=10, ALUOp=11, ExtOp=0. Go to IWB.
  - IWB 11: RegDst=0, Mem2Reg=0, RegWrite=1. Go to FETCH.
  - Codes 12-15 are unreachable. If entered, go to FETCH.
- Unlisted outputs are 0 in every state.
- Wait counter: increments each cycle a memory state (FETCH, MEMRD, MEMWR) holds with MemReady=0. It clears on a state change.
- Timeout: when the counter reaches MEM_WAIT_MAX with MemReady still 0, pulse MemTimeout, drop the request, and go to FETCH without any write. If MemReady=1 in that same cycle, the access completes normally and no timeout is raised.
- Illegal R-type funct: with OpCode=0, Funct outside {0x20, 0x22, 0x24, 0x25, 0x2A}, IllegalOp pulses in DECODE and the state returns to FETCH.
- Latency in cycles with zero wait: lw 5, sw 4, R-type 4, ori 4, beq 3, j 3. Each wait cycle adds 1.

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- Defined: CycleCount increments every non-reset cycle. InstrCount increments on each return to FETCH from a completing state. It does not count returns caused by IllegalOp or timeout. Both counters wrap modulo 2^32.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- The shared definitions header holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI.
  - Legal funct codes.
  - The 4-bit state encodings.
  - ALUOp codes, ALUSrcB codes and PCSource codes.
- One sub-module, ctrl_wait_timer: the wait counter plus timeout compare, parameterised by MEM_WAIT_MAX and CNT_W.

Test Plan:
- Reset hold: RST=1 for 3 cycles, then release -> State=0, MemRead=1, and IRWrite=0 until MemReady=1.
- lw with MemReady=1 always: OpCode=0x23 -> State sequence 0,1,2,3,4,0. RegWrite=1 and Mem2Reg=1 only in state 4.
- beq: OpCode=0x04 with Zero=1 -> PCWrite=1 and PCSource=01 in state 8. With Zero=0 -> PCWrite=0. 3 cycles total.
- Wait states: sw with MemReady low for 3 cycles in MEMWR -> MemWrite held 4 cycles and State=5 throughout. No timeout.
- Timeout: MemReady=0 forever in FETCH, MEM_WAIT_MAX=15 -> MemTimeout pulses once at the 15th wait cycle. IRWrite and PCWrite never assert.
- Illegal: OpCode=0x3F -> IllegalOp pulses in DECODE, next State=0. With MULTICYCLE_PERF_EN, InstrCount is unchanged.
